// File: rtl/fft_frame_ctrl_if.sv
// Stream, datapath and result-stream signals of the FFT frame controller.
// The controller connects through the slave modport; the environment (sample source,
// datapath, result sink) uses the master modport.
interface fft_frame_ctrl_if #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 8
);
  // Serial sample input
  logic             s_valid;
  logic [W-1:0]     s_data;
  logic             s_ready;
  logic             mode;
  // Parallel datapath frame
  logic             dp_start;
  logic [N*W-1:0]   dp_data;
  logic             dp_ind;
  logic [N*W-1:0]   dp_result;
  // Serial result output
  logic             m_valid;
  logic [W-1:0]     m_data;
  logic             m_ready;
  logic             m_last;

  modport slave (
    input  s_valid, s_data, mode, dp_result, m_ready,
    output s_ready, dp_start, dp_data, dp_ind, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_data, mode, dp_result, m_ready,
    input  s_ready, dp_start, dp_data, dp_ind, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the 8-lane FFT/filter datapath: collects N serial samples,
// issues them in parallel, waits the datapath latency, captures and streams the result.
module fft_frame_ctrl #(
  parameter int unsigned W   = 8,
  parameter int unsigned N   = 8,
  parameter int unsigned LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_frame_ctrl_if.slave      bus,
  output logic                 busy,
  output logic [7:0]           frame_cnt
);

  localparam int unsigned CntW  = (N > 1) ? $clog2(N) : 1;
  // wait_cnt only needs to reach LAT-1, the cycle whose closing edge captures the result
  localparam int unsigned WaitW = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [CntW-1:0]  LastLane = CntW'(N - 1);
  localparam logic [WaitW-1:0] LastWait = WaitW'(LAT - 1);

  typedef enum logic [1:0] {
    StFill,
    StIssue,
    StWait,
    StDrain
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    fill_cnt_q, fill_cnt_d;
  logic [CntW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [N*W-1:0]     sample_buf_q, sample_buf_d;
  logic [N*W-1:0]     res_buf_q, res_buf_d;
  logic [N*W-1:0]     dp_data_q, dp_data_d;
  logic               dp_ind_q, dp_ind_d;
  logic               frame_mode_q, frame_mode_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic [W-1:0]       m_data_c;

  // State and datapath registers; reset discards any partial or in-flight frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFill;
      fill_cnt_q   <= '0;
      drain_cnt_q  <= '0;
      wait_cnt_q   <= '0;
      sample_buf_q <= '0;
      res_buf_q    <= '0;
      dp_data_q    <= '0;
      dp_ind_q     <= 1'b0;
      frame_mode_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      sample_buf_q <= sample_buf_d;
      res_buf_q    <= res_buf_d;
      dp_data_q    <= dp_data_d;
      dp_ind_q     <= dp_ind_d;
      frame_mode_q <= frame_mode_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // Next-state: fill buffer, issue frame, count latency, drain result
  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    sample_buf_d = sample_buf_q;
    res_buf_d    = res_buf_q;
    dp_data_d    = dp_data_q;
    dp_ind_d     = dp_ind_q;
    frame_mode_d = frame_mode_q;
    frame_cnt_d  = frame_cnt_q;

    unique case (state_q)
      StFill: begin
        if (bus.s_valid) begin
          for (int k = 0; k < int'(N); k++) begin
            if (fill_cnt_q == CntW'(k)) sample_buf_d[k*W +: W] = bus.s_data;
          end
          if (fill_cnt_q == '0) frame_mode_d = bus.mode;
          if (fill_cnt_q == LastLane) begin
            // dp_data/dp_ind change only here so they stay stable until the next issue
            dp_data_d  = sample_buf_d;
            dp_ind_d   = (fill_cnt_q == '0) ? bus.mode : frame_mode_q;
            fill_cnt_d = '0;
            state_d    = StIssue;
          end else begin
            fill_cnt_d = fill_cnt_q + CntW'(1);
          end
        end
      end
      StIssue: begin
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        if (wait_cnt_q == LastWait) begin
          res_buf_d = bus.dp_result;
          state_d   = StDrain;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StDrain: begin
        if (bus.m_ready) begin
          if (drain_cnt_q == LastLane) begin
            drain_cnt_d = '0;
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = StFill;
          end else begin
            drain_cnt_d = drain_cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  // Output lane mux; m_data is forced to zero outside DRAIN
  always_comb begin
    m_data_c = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (state_q == StDrain && drain_cnt_q == CntW'(k)) m_data_c = res_buf_q[k*W +: W];
    end
  end

  assign bus.s_ready  = (state_q == StFill);
  assign bus.dp_start = (state_q == StIssue);
  assign bus.dp_data  = dp_data_q;
  assign bus.dp_ind   = dp_ind_q;
  assign bus.m_valid  = (state_q == StDrain);
  assign bus.m_data   = m_data_c;
  assign bus.m_last   = (state_q == StDrain) && (drain_cnt_q == LastLane);
  assign busy         = (state_q != StFill);
  assign frame_cnt    = frame_cnt_q;

endmodule
